interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Parametrised, memory-mapped platform interrupt controller.
- Aggregates up to 32 external interrupt sources into the single external_interrupt input of the drisc core.
- Each source has:
  - level or edge gateway;
  - per-source priority;
  - enable;
  - global threshold;
  - claim/complete handshake.
- Sits on the core's data bus beside memory; the core reaches it through loads and stores.

Parameters:
- NUM_SOURCES, 16, number of source IDs including reserved ID 0. Legal range 2..32.
- PRIORITY_BITS, 3, width of each priority field and of the threshold.
- SYNC_STAGES, 2, synchroniser flops per source input. Minimum 2.
- BASE_ADDRESS, 32'h0C00_0000, base of the 4 KiB register window. Must be 4 KiB aligned.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- sources  in  NUM_SOURCES  raw interrupt requests. Bit 0 is ignored.
- address_bus  in  32  byte address from the core.
- data_bus_in  in  32  write data (core data_bus_out).
- data_size  in  2  access size; 2'b10 = word.
- write  in  1  store strobe, one cycle.
- read  in  1  load strobe, one cycle.
- data_bus_out  out  32  read data.
- selected  out  1  address_bus lies inside the window; used for the bus read mux.
- external_interrupt  out  1  to the core.

Behaviour:
Address decode
- selected = (address_bus[31:12] == BASE_ADDRESS[31:12]), combinational.
- Only word-aligned offsets are decoded. Any other offset reads 0 and ignores writes.

Register map (byte offsets)
- 0x000+4*i priority[i], RW, PRIORITY_BITS wide, zero-extended. i=0 and i>=NUM_SOURCES read 0 and ignore writes.
- 0x080 pending, RO.
- 0x084 mode, RW; 1 = edge, 0 = level.
- 0x100 enable, RW.
- 0x200 threshold, RW.
- 0x204 claim on read / complete on write.
- Bit 0 of pending, mode and enable is always 0. Bits >= NUM_SOURCES are always 0.

Bus access
- Writes take effect at the rising edge where write && selected && data_size==2'b10. Other sizes are ignored.
- Reads are combinational: data_bus_out is valid whenever read && selected, otherwise 0.
- Side effects of a claim read occur at the rising edge where read is high.

Gateway (per source i)
- sources[i] passes through SYNC_STAGES flops, giving s_i.
- Level mode:
  - pending[i] sets while s_i==1 && !in_service[i].
  - pending[i] clears when s_i drops before claim.
- Edge mode:
  - A rising edge of s_i sets pending[i] if !in_service[i]. Otherwise it sets deferred[i]; at most one edge is remembered.
  - pending[i] is not cleared by s_i falling.
- Switching mode clears pending[i] and deferred[i] at the same edge.

Arbitration (combinational)
- eligible[i] = pending[i] && enable[i] && priority[i] > threshold.
- best_id = eligible source with highest priority; ties go to the lowest ID.
- best_id = 0 if no source is eligible.

Interrupt output
- external_interrupt is registered: best_id != 0, one cycle latency.

Claim read
- Returns best_id.
- If best_id != 0, at the same edge: pending[best_id] <= 0, in_service[best_id] <= 1.
- Claim with nothing eligible returns 0 and changes nothing.

Complete write
- Data [4:0] = ID.
- If in_service[ID]: clear in_service[ID]; if deferred[ID], move it into pending[ID] and clear deferred.
- A completion naming an ID not in service, or ID 0, is ignored.

Simultaneous events
- Claim and a new edge on the same source in the same cycle: the claim wins and the edge lands in deferred.
- Disabling a pending source leaves it pending but ineligible.

Reset
- Asynchronous: all priority, mode, enable, threshold, pending, deferred, in_service and synchroniser flops go to 0.
- external_interrupt = 0.
- A reset mid-service drops all in-service state.

Decomposition:
- Package interrupt_controller_pkg: register offset constants, MAX_SOURCES=32, and a source-ID width localparam of 5.
- Sub-module interrupt_gateway, one instance per source:
  - synchroniser, edge detect;
  - pending, deferred and in_service flops;
  - claim and complete strobes as inputs.
- Arbitration tree, register file and bus decode stay in the top.

Test Plan:
- Level source 3, priority 5, enable bit 3, threshold 0, sources[3]=1 -> after SYNC_STAGES+1 cycles pending=0x8, external_interrupt=1. Claim read returns 3. external_interrupt=0 one cycle later. Write 3 to 0x204 with the source still high -> re-pends, line reasserts.
- Sources 2 and 5 both priority 4 and enabled -> claim returns 2. Raise priority[5] to 6 -> claim returns 5.
- Threshold 4, source 7 priority 4 -> external_interrupt stays 0. Threshold 3 -> line asserts.
- Edge mode, source 9: pulse -> claim 9. Pulse twice during service -> one deferred. Complete 9 -> pending=0x200. Claim 9 again. Complete 9 -> pending 0.
- Byte store (data_size=2'b00) to enable -> register unchanged. Completion with wrong ID 4 while 9 is in service -> ignored.
- Drop reset mid-service while external_interrupt=1 -> all registers read 0 and the line is 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the platform interrupt controller: register offsets,
// source limits and the helper that builds the legal-source bit mask.
package interrupt_controller_pkg;

    localparam int MAX_SOURCES = 32;
    localparam int ID_WIDTH    = 5;

    localparam logic [11:0] OFFSET_PRIORITY  = 12'h000;
    localparam logic [11:0] OFFSET_PENDING   = 12'h080;
    localparam logic [11:0] OFFSET_MODE      = 12'h084;
    localparam logic [11:0] OFFSET_ENABLE    = 12'h100;
    localparam logic [11:0] OFFSET_THRESHOLD = 12'h200;
    localparam logic [11:0] OFFSET_CLAIM     = 12'h204;

    // Bit 0 is the reserved ID and bits at or above num_sources do not exist.
    function automatic logic [MAX_SOURCES-1:0] source_mask(input int num_sources);
        logic [MAX_SOURCES-1:0] mask;
        mask = '0;
        for (int i = 1; i < MAX_SOURCES; i++) begin
            if (i < num_sources) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/interrupt_gateway.sv
// Per-source gateway: input synchroniser, edge detect and the pending,
// deferred and in-service state driven by the claim/complete strobes.
module interrupt_gateway
    import interrupt_controller_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic source_i,
    input  logic edge_mode_i,
    input  logic mode_change_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_prev_q;
    logic                   pending_q, pending_d;
    logic                   deferred_q, deferred_d;
    logic                   in_service_q, in_service_d;
    logic                   level;
    logic                   rise;

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level && !level_prev_q;

    // A claim always wins: an edge arriving with the claim is held as deferred.
    always_comb begin
        pending_d    = pending_q;
        deferred_d   = deferred_q;
        in_service_d = in_service_q;
        if (mode_change_i) begin
            pending_d  = 1'b0;
            deferred_d = 1'b0;
        end else if (edge_mode_i) begin
            if (complete_i && in_service_q && deferred_q) begin
                pending_d  = 1'b1;
                deferred_d = 1'b0;
            end
            if (rise) begin
                if (claim_i || (in_service_q && !complete_i)) begin
                    deferred_d = 1'b1;
                end else begin
                    pending_d = 1'b1;
                end
            end
        end else begin
            pending_d = level && !in_service_q;
        end
        if (complete_i && in_service_q) begin
            in_service_d = 1'b0;
        end
        if (claim_i) begin
            pending_d    = 1'b0;
            in_service_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q       <= '0;
            level_prev_q <= 1'b0;
            pending_q    <= 1'b0;
            deferred_q   <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], source_i};
            level_prev_q <= level;
            pending_q    <= pending_d;
            deferred_q   <= deferred_d;
            in_service_q <= in_service_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller: register file, bus decode and priority
// arbitration over one gateway per source, driving the core's interrupt line.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_SOURCES   = 16,
    parameter int          PRIORITY_BITS = 3,
    parameter int          SYNC_STAGES   = 2,
    parameter logic [31:0] BASE_ADDRESS  = 32'h0C00_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] sources,
    input  logic [31:0]            address_bus,
    input  logic [31:0]            data_bus_in,
    input  logic [1:0]             data_size,
    input  logic                   write,
    input  logic                   read,
    output logic [31:0]            data_bus_out,
    output logic                   selected,
    output logic                   external_interrupt
);

    localparam logic [MAX_SOURCES-1:0] SRC_MASK = source_mask(NUM_SOURCES);

    logic [PRIORITY_BITS-1:0] priority_q [1:NUM_SOURCES-1];
    logic [MAX_SOURCES-1:0]   mode_q;
    logic [MAX_SOURCES-1:0]   enable_q;
    logic [PRIORITY_BITS-1:0] threshold_q;
    logic                     irq_q, irq_d;

    logic [11:0]              offset;
    logic                     word_access;
    logic                     reg_write;
    logic                     claim_read;
    logic                     complete_write;
    logic [MAX_SOURCES-1:0]   mode_change;
    logic [NUM_SOURCES-1:0]   gw_pending;
    logic [MAX_SOURCES-1:0]   pending;
    logic [NUM_SOURCES-1:0]   claim_vec;
    logic [NUM_SOURCES-1:0]   complete_vec;
    logic [ID_WIDTH-1:0]      best_id;
    logic [PRIORITY_BITS-1:0] best_prio;
    logic [31:0]              read_data;

    assign offset         = address_bus[11:0];
    assign selected       = (address_bus[31:12] == BASE_ADDRESS[31:12]);
    assign word_access    = selected && (offset[1:0] == 2'b00);
    assign reg_write      = write && word_access && (data_size == 2'b10);
    assign claim_read     = read && word_access && (offset == OFFSET_CLAIM);
    assign complete_write = reg_write && (offset == OFFSET_CLAIM);
    assign mode_change    = (reg_write && offset == OFFSET_MODE) ?
                            ((data_bus_in & SRC_MASK) ^ mode_q) : '0;
    assign pending        = MAX_SOURCES'(gw_pending) & SRC_MASK;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_gateway
        interrupt_gateway #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_gateway (
            .clock        (clock),
            .reset        (reset),
            .source_i     (sources[g]),
            .edge_mode_i  (mode_q[g]),
            .mode_change_i(mode_change[g]),
            .claim_i      (claim_vec[g]),
            .complete_i   (complete_vec[g]),
            .pending_o    (gw_pending[g])
        );
    end

    // Strict greater-than keeps the lowest ID on a priority tie.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 1; i < NUM_SOURCES; i++) begin
            if (pending[i] && enable_q[i] && priority_q[i] > threshold_q
                && priority_q[i] > best_prio) begin
                best_id   = ID_WIDTH'(i);
                best_prio = priority_q[i];
            end
        end
    end

    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        for (int i = 1; i < NUM_SOURCES; i++) begin
            claim_vec[i]    = claim_read && (best_id == ID_WIDTH'(i));
            complete_vec[i] = complete_write && (data_bus_in[ID_WIDTH-1:0] == ID_WIDTH'(i));
        end
    end

    always_comb begin
        read_data = '0;
        if (read && word_access) begin
            if (offset == OFFSET_PENDING) begin
                read_data = pending;
            end else if (offset == OFFSET_MODE) begin
                read_data = mode_q;
            end else if (offset == OFFSET_ENABLE) begin
                read_data = enable_q;
            end else if (offset == OFFSET_THRESHOLD) begin
                read_data = 32'(threshold_q);
            end else if (offset == OFFSET_CLAIM) begin
                read_data = 32'(best_id);
            end else begin
                for (int i = 1; i < NUM_SOURCES; i++) begin
                    if (offset == OFFSET_PRIORITY + 12'(4 * i)) begin
                        read_data = 32'(priority_q[i]);
                    end
                end
            end
        end
    end

    assign data_bus_out = read_data;
    assign irq_d        = (best_id != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NUM_SOURCES; i++) begin
                priority_q[i] <= '0;
            end
            mode_q      <= '0;
            enable_q    <= '0;
            threshold_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            irq_q <= irq_d;
            if (reg_write) begin
                for (int i = 1; i < NUM_SOURCES; i++) begin
                    if (offset == OFFSET_PRIORITY + 12'(4 * i)) begin
                        priority_q[i] <= data_bus_in[PRIORITY_BITS-1:0];
                    end
                end
                if (offset == OFFSET_MODE) begin
                    mode_q <= data_bus_in & SRC_MASK;
                end
                if (offset == OFFSET_ENABLE) begin
                    enable_q <= data_bus_in & SRC_MASK;
                end
                if (offset == OFFSET_THRESHOLD) begin
                    threshold_q <= data_bus_in[PRIORITY_BITS-1:0];
                end
            end
        end
    end

    assign external_interrupt = irq_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: stimulus queues expected read data
// and line levels, a negedge monitor pops and compares them.
module tb_interrupt_controller;

    localparam logic [31:0] BASE = 32'h0C00_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sources = '0;
    logic [31:0] addressBus = '0;
    logic [31:0] dataBusIn = '0;
    logic [1:0]  dataSize = 2'b10;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] dataBusOut;
    logic        selected;
    logic        externalInterrupt;

    typedef struct {
        logic [31:0] value;
        string       name;
    } expect_t;

    expect_t readQueue[$];
    expect_t irqQueue[$];
    expect_t readHead;
    expect_t irqHead;
    logic    irqProbe = 1'b0;
    int      testsRun = 0;
    int      testsFailed = 0;

    interrupt_controller #(
        .NUM_SOURCES  (16),
        .PRIORITY_BITS(3),
        .SYNC_STAGES  (2),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .sources           (sources),
        .address_bus       (addressBus),
        .data_bus_in       (dataBusIn),
        .data_size         (dataSize),
        .write             (write),
        .read              (read),
        .data_bus_out      (dataBusOut),
        .selected          (selected),
        .external_interrupt(externalInterrupt)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every selected read and every line probe consumes one expectation.
    always @(negedge clock) begin
        if (read && selected) begin
            if (readQueue.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_read: got 0x%08h, expected no read", dataBusOut);
            end else begin
                readHead = readQueue.pop_front();
                checkOutput(readHead.name, dataBusOut, readHead.value);
            end
        end
        if (irqProbe) begin
            if (irqQueue.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_probe: got %0b, expected no probe", externalInterrupt);
            end else begin
                irqHead = irqQueue.pop_front();
                checkOutput(irqHead.name, {31'b0, externalInterrupt}, irqHead.value);
            end
        end
    end

    task automatic applyStimulus(input bit isWrite, input logic [11:0] offset,
                                 input logic [31:0] value, input logic [1:0] size,
                                 input string name);
        @(posedge clock);
        #1;
        addressBus = BASE | 32'(offset);
        dataSize   = size;
        if (isWrite) begin
            dataBusIn = value;
            write     = 1'b1;
        end else begin
            readQueue.push_back('{value, name});
            read = 1'b1;
        end
        @(posedge clock);
        #1;
        write      = 1'b0;
        read       = 1'b0;
        addressBus = '0;
        dataBusIn  = '0;
        dataSize   = 2'b10;
    endtask

    task automatic wr(input logic [11:0] offset, input logic [31:0] value);
        applyStimulus(1'b1, offset, value, 2'b10, "write");
    endtask

    task automatic rd(input logic [11:0] offset, input logic [31:0] expected, input string name);
        applyStimulus(1'b0, offset, expected, 2'b10, name);
    endtask

    task automatic expectIrq(input logic expected, input string name);
        irqQueue.push_back('{32'(expected), name});
        irqProbe = 1'b1;
        @(negedge clock);
        #1;
        irqProbe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse(input int idx);
        sources[idx] = 1'b1;
        idle(1);
        sources[idx] = 1'b0;
        idle(4);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        // Reset state and decode corner cases
        rd(12'h080, 32'h0, "reset_pending");
        rd(12'h100, 32'h0, "reset_enable");
        rd(12'h204, 32'h0, "reset_claim");
        expectIrq(1'b0, "reset_irq");
        wr(12'h000, 32'h7);
        rd(12'h000, 32'h0, "priority0_reserved");
        wr(12'h00C, 32'h5);
        rd(12'h00C, 32'h5, "priority3_rw");
        rd(12'h102, 32'h0, "unaligned_read");

        // Level source 3
        wr(12'h100, 32'h8);
        sources[3] = 1'b1;
        idle(5);
        rd(12'h080, 32'h8, "level_pending");
        expectIrq(1'b1, "level_irq");
        rd(12'h204, 32'h3, "level_claim");
        expectIrq(1'b1, "irq_latency_hold");
        expectIrq(1'b0, "irq_after_claim");
        rd(12'h080, 32'h0, "pending_in_service");
        wr(12'h204, 32'h3);
        idle(2);
        expectIrq(1'b1, "level_repend_irq");
        rd(12'h080, 32'h8, "level_repend");
        rd(12'h204, 32'h3, "level_claim2");
        sources[3] = 1'b0;
        idle(4);
        wr(12'h204, 32'h3);
        idle(3);
        rd(12'h080, 32'h0, "level_dropped");

        // Priority tie and reprioritisation
        wr(12'h008, 32'h4);
        wr(12'h014, 32'h4);
        wr(12'h100, 32'h24);
        sources[2] = 1'b1;
        sources[5] = 1'b1;
        idle(5);
        rd(12'h204, 32'h2, "tie_lowest_id");
        wr(12'h204, 32'h2);
        idle(3);
        wr(12'h014, 32'h6);
        rd(12'h204, 32'h5, "higher_priority");
        sources[2] = 1'b0;
        sources[5] = 1'b0;
        idle(4);
        wr(12'h204, 32'h5);
        idle(2);
        rd(12'h080, 32'h0, "tie_cleanup");
        wr(12'h100, 32'h0);

        // Threshold boundary and disable
        wr(12'h200, 32'h4);
        wr(12'h01C, 32'h4);
        wr(12'h100, 32'h80);
        sources[7] = 1'b1;
        idle(5);
        expectIrq(1'b0, "threshold_equal_blocks");
        rd(12'h080, 32'h80, "threshold_pending");
        rd(12'h204, 32'h0, "claim_nothing");
        wr(12'h200, 32'h3);
        idle(1);
        expectIrq(1'b1, "threshold_below_asserts");
        wr(12'h100, 32'h0);
        idle(1);
        expectIrq(1'b0, "disabled_irq");
        rd(12'h080, 32'h80, "disabled_still_pending");
        wr(12'h100, 32'h80);
        rd(12'h204, 32'h7, "threshold_claim");
        sources[7] = 1'b0;
        idle(4);
        wr(12'h204, 32'h7);
        wr(12'h200, 32'h0);
        wr(12'h100, 32'h0);

        // Edge source 9 with deferral
        wr(12'h084, 32'h200);
        wr(12'h024, 32'h2);
        wr(12'h100, 32'h200);
        pulse(9);
        rd(12'h080, 32'h200, "edge_pending");
        rd(12'h204, 32'h9, "edge_claim");
        pulse(9);
        pulse(9);
        rd(12'h080, 32'h0, "edge_deferred_not_pending");
        applyStimulus(1'b1, 12'h100, 32'h0, 2'b00, "byte_write");
        rd(12'h100, 32'h200, "byte_write_ignored");
        wr(12'h204, 32'h4);
        rd(12'h080, 32'h0, "wrong_id_ignored");
        rd(12'h204, 32'h0, "wrong_id_claim");
        wr(12'h204, 32'h9);
        idle(1);
        rd(12'h080, 32'h200, "deferred_to_pending");
        rd(12'h204, 32'h9, "edge_claim2");
        wr(12'h204, 32'h9);
        idle(1);
        rd(12'h080, 32'h0, "single_deferral");

        // Asynchronous reset mid-service
        wr(12'h100, 32'h208);
        sources[3] = 1'b1;
        pulse(9);
        idle(1);
        rd(12'h204, 32'h3, "pre_reset_claim");
        idle(2);
        expectIrq(1'b1, "pre_reset_irq");
        @(posedge clock);
        #1;
        reset = 1'b0;
        expectIrq(1'b0, "async_reset_irq");
        rd(12'h080, 32'h0, "reset_mid_pending");
        rd(12'h100, 32'h0, "reset_mid_enable");
        rd(12'h084, 32'h0, "reset_mid_mode");
        rd(12'h00C, 32'h0, "reset_mid_priority");
        rd(12'h204, 32'h0, "reset_mid_claim");
        sources = '0;
        idle(1);
        reset = 1'b1;
        idle(3);
        expectIrq(1'b0, "post_reset_irq");
        rd(12'h080, 32'h0, "post_reset_pending");

        for (int i = 0; i < 20 && (readQueue.size() != 0 || irqQueue.size() != 0); i++) begin
            @(posedge clock);
        end
        if (readQueue.size() != 0 || irqQueue.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: got %0d entries left, expected 0",
                     readQueue.size() + irqQueue.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
